// File: rtl/sevenseg_reader.sv
// Rebuilds 3-digit decimal frames received as 7-segment patterns (hundreds first)
// into 8-bit binary values on a valid/ready output, with a one-cycle error strobe.
module sevenseg_reader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       seg_start,
  input  logic       seg_valid,
  output logic       seg_ready,
  output logic [7:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {S_HUND, S_TENS, S_UNIT, S_OUT} state_t;

  localparam logic [1:0] ERR_INVALID  = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_SYNC     = 2'b11;

  // Returns {valid, digit}; only exact pattern matches are accepted.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'b1111110: seg_decode = {1'b1, 4'd0};
      7'b0110000: seg_decode = {1'b1, 4'd1};
      7'b1101101: seg_decode = {1'b1, 4'd2};
      7'b1111001: seg_decode = {1'b1, 4'd3};
      7'b0110011: seg_decode = {1'b1, 4'd4};
      7'b1011011: seg_decode = {1'b1, 4'd5};
      7'b1011111: seg_decode = {1'b1, 4'd6};
      7'b1110000: seg_decode = {1'b1, 4'd7};
      7'b1111111: seg_decode = {1'b1, 4'd8};
      7'b1110011: seg_decode = {1'b1, 4'd9};
      default:    seg_decode = 5'd0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  acc_q, acc_d;
  logic [7:0]  out_q, out_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        accept;
  logic        dig_ok;
  logic [3:0]  dig;
  logic [9:0]  mac;

  assign seg_ready = (state_q != S_OUT);
  assign out_valid = (state_q == S_OUT);
  assign out       = out_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

  assign accept        = seg_valid && seg_ready;
  assign {dig_ok, dig} = seg_decode(seg_in);
  // acc never exceeds 99 when a digit is appended, so 999 fits in 10 bits.
  assign mac           = acc_q * 10'd10 + {6'd0, dig};

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_d      = out_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      S_HUND: begin
        if (accept) begin
          if (!dig_ok) begin
            err_d      = 1'b1;
            err_code_d = ERR_INVALID;
          end else if (!seg_start) begin
            err_d      = 1'b1;
            err_code_d = ERR_SYNC;
          end else begin
            acc_d   = {6'd0, dig};
            state_d = S_TENS;
          end
        end
      end
      S_TENS, S_UNIT: begin
        if (accept) begin
          if (!dig_ok) begin
            err_d      = 1'b1;
            err_code_d = ERR_INVALID;
            state_d    = S_HUND;
          end else if (seg_start) begin
            // Resync: the start-marked digit opens a fresh frame.
            err_d      = 1'b1;
            err_code_d = ERR_SYNC;
            acc_d      = {6'd0, dig};
            state_d    = S_TENS;
          end else if (state_q == S_TENS) begin
            acc_d   = mac;
            state_d = S_UNIT;
          end else if (mac > 10'd255) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVERFLOW;
            acc_d      = mac;
            state_d    = S_HUND;
          end else begin
            acc_d   = mac;
            out_d   = mac[7:0];
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_HUND;
      end
      default: state_d = S_HUND;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_HUND;
      acc_q      <= 10'd0;
      out_q      <= 8'd0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

endmodule
